kicp_mem_arbiter: RTL and testbench

KICP_MEM_ARBITER -- requirements
Module: kicp_mem_arbiter

---
 rtl/kicp_mem_arbiter_pkg.sv | 40 ++++
 rtl/kicp_mem_arbiter_if.sv | 38 +++
 rtl/kicp_rr_picker.sv | 38 +++
 rtl/kicp_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_kicp_mem_arbiter.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/kicp_mem_arbiter_pkg.sv
// kicp_mem_arbiter_pkg
//   Shared KICP definitions for the SRAM arbiter slice: the SRAM address
//   width, the SRAM op codes, the arbiter FSM state encoding and two small
//   helper functions.
//   Ports: none (package).
`ifndef KICP_SRAM_AWIDTH
`define KICP_SRAM_AWIDTH 12
`endif

package kicp_mem_arbiter_pkg;

  localparam int KICP_SRAM_AWIDTH = `KICP_SRAM_AWIDTH;

  // SRAM op codes; 2'b10 is illegal and is treated exactly like OP_NONE.
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Only a legal read or write counts as a request.
  function automatic logic is_request(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

  // Index of the set bit of a one-hot vector (up to 8 requesters).
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kicp_mem_arbiter_if.sv
// kicp_mem_arbiter_if
//   Bundles the requester-side and SRAM-side buses of the arbiter.
//   Signals:
//     req_mem_operation [2*NUM_REQ]     per-requester op codes
//     req_addr          [AWIDTH*NUM_REQ] per-requester addresses
//     req_wdata         [32*NUM_REQ]    per-requester write data
//     req_opdone        [NUM_REQ]       per-requester completion strobe
//     req_rdata         [32]            broadcast read data
//     sram_mem_operation[2], sram_addr[AWIDTH], sram_wdata[32]  to SRAM ctrl
//     sram_opdone, sram_rdata[32]       from SRAM ctrl
//   Modports: slave = arbiter side, master = requesters + SRAM model side.
interface kicp_mem_arbiter_if
  import kicp_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AWIDTH  = KICP_SRAM_AWIDTH
);
  logic [2*NUM_REQ-1:0]      req_mem_operation;
  logic [AWIDTH*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0]     req_wdata;
  logic [NUM_REQ-1:0]        req_opdone;
  logic [31:0]               req_rdata;
  logic [1:0]                sram_mem_operation;
  logic [AWIDTH-1:0]         sram_addr;
  logic [31:0]               sram_wdata;
  logic                      sram_opdone;
  logic [31:0]               sram_rdata;

  modport slave (
    input  req_mem_operation, req_addr, req_wdata, sram_opdone, sram_rdata,
    output req_opdone, req_rdata, sram_mem_operation, sram_addr, sram_wdata
  );

  modport master (
    output req_mem_operation, req_addr, req_wdata, sram_opdone, sram_rdata,
    input  req_opdone, req_rdata, sram_mem_operation, sram_addr, sram_wdata
  );
endinterface

// File: rtl/kicp_rr_picker.sv
// kicp_rr_picker
//   Purely combinational round-robin picker: returns the first requesting
//   index at or after (last_owner+1) mod NUM_REQ as a one-hot vector.
//   Ports:
//     i_req        [NUM_REQ]  request vector
//     i_last_owner [3]        index of the previous owner
//     o_winner     [NUM_REQ]  one-hot winner (zero when nobody requests)
module kicp_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [2:0]         i_last_owner,
  output logic [NUM_REQ-1:0] o_winner
);

  logic w_found;
  int   w_cand;

  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    o_winner = '0;
    w_found  = 1'b0;
    w_cand   = 0;
    // Walk candidates in priority order; the inner loop keeps every bit
    // select constant so the index never needs a variable-width select.
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (int'(i_last_owner) + 1 + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && (i == w_cand) && i_req[i]) begin
          o_winner[i] = 1'b1;
          w_found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kicp_mem_arbiter.sv
// kicp_mem_arbiter
//   Shares one SRAM controller port between NUM_REQ accelerator requesters.
//   An owner keeps the port for as long as it holds a legal op code (atomic
//   bursts); each release is followed by one dead GAP cycle. A watchdog sets
//   a sticky error if an owner waits TIMEOUT cycles without sram_opdone,
//   after which the grant is frozen until reset.
//   Ports:
//     clk          clock, rising edge
//     reset        synchronous active-high reset
//     bus          kicp_mem_arbiter_if.slave (requester and SRAM buses)
//     grant        [NUM_REQ] registered one-hot owner
//     busy         high whenever grant is nonzero
//     timeout_err  sticky watchdog error
module kicp_mem_arbiter
  import kicp_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AWIDTH  = KICP_SRAM_AWIDTH,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  kicp_mem_arbiter_if.slave  bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  arb_state_e         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [2:0]         r_last_owner, w_last_owner_nxt;
  logic [NUM_REQ-1:0] w_req, w_pick;
  logic [WDW-1:0]     r_wd_cnt;
  logic               r_timeout_err;
  logic [1:0]         w_own_op;
  logic [AWIDTH-1:0]  w_own_addr;
  logic [31:0]        w_own_wdata;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req[i] = is_request(bus.req_mem_operation[2*i +: 2]);
    end
  end

  kicp_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .i_req        (w_req),
    .i_last_owner (r_last_owner),
    .o_winner     (w_pick)
  );

  // Owner's request fields; grant is one-hot so at most one term is active.
  always_comb begin
    w_own_op    = OP_NONE;
    w_own_addr  = '0;
    w_own_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_own_op    = bus.req_mem_operation[2*i +: 2];
        w_own_addr  = bus.req_addr[AWIDTH*i +: AWIDTH];
        w_own_wdata = bus.req_wdata[32*i +: 32];
      end
    end
  end

  // Next-state logic; a raised watchdog error freezes the FSM and grant.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_owner_nxt = r_last_owner;
    if (!r_timeout_err) begin
      unique case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            w_grant_nxt      = w_pick;
            w_last_owner_nxt = onehot_idx(8'(w_pick));
            w_state_nxt      = ST_OWN;
          end
        end
        ST_OWN: begin
          if (!is_request(w_own_op)) begin
            w_grant_nxt = '0;
            w_state_nxt = ST_GAP;
          end
        end
        ST_GAP:  w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_owner <= 3'(NUM_REQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  // Watchdog: the count is zero outside OWN, so entering OWN starts from 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else if ((r_state != ST_OWN) || bus.sram_opdone) begin
      r_wd_cnt <= '0;
    end else if (!r_timeout_err) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
      if (r_wd_cnt == WDW'(TIMEOUT - 1)) r_timeout_err <= 1'b1;
    end
  end

  // SRAM side is a zero-latency mux of the owner; reset kills any in-flight
  // access in the reset cycle itself.
  always_comb begin
    bus.sram_mem_operation = OP_NONE;
    bus.sram_addr          = '0;
    bus.sram_wdata         = '0;
    bus.req_opdone         = '0;
    if ((r_state == ST_OWN) && !reset) begin
      bus.sram_mem_operation = is_request(w_own_op) ? w_own_op : OP_NONE;
      bus.sram_addr          = w_own_addr;
      bus.sram_wdata         = w_own_wdata;
      bus.req_opdone         = r_grant & {NUM_REQ{bus.sram_opdone}};
    end
  end

  assign bus.req_rdata = bus.sram_rdata;
  assign grant         = r_grant;
  assign busy          = |r_grant;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_kicp_mem_arbiter.sv
// tb_kicp_mem_arbiter
//   Directed bench for kicp_mem_arbiter (NUM_REQ=4, AWIDTH=12, TIMEOUT=16).
//   A per-cycle vector table covers bursts, two-requester ordering, writes,
//   illegal codes and the GAP cycle; hand-written sequences cover fairness,
//   the watchdog and reset during an ownership.
module tb_kicp_mem_arbiter;

  localparam logic [11:0] A0 = 12'h010, A1 = 12'h011, A2 = 12'h020, A3 = 12'h033;
  localparam logic [31:0] W0 = 32'h1111_0000, W1 = 32'h2222_1111;
  localparam logic [31:0] W2 = 32'hDEAD_BEEF, W3 = 32'h4444_3333;

  typedef struct {
    logic        rst;
    logic [7:0]  op;     // {op3, op2, op1, op0}
    logic        sdone;
    logic [3:0]  g;      // expected grant
    logic [1:0]  sop;    // expected sram_mem_operation
    logic [11:0] sa;     // expected sram_addr
    logic [31:0] sw;     // expected sram_wdata
    logic [3:0]  dn;     // expected req_opdone
    logic        err;    // expected timeout_err
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] grant;
  logic       busy;
  logic       timeout_err;
  int         n_vec = 0;
  int         n_bad = 0;
  vec_t       vecs[$];

  always #5 clk = ~clk;

  kicp_mem_arbiter_if #(.NUM_REQ(4), .AWIDTH(12)) bus ();

  kicp_mem_arbiter #(.NUM_REQ(4), .AWIDTH(12), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Move to the next falling edge, drive inputs, let combinational paths settle.
  task automatic cyc(input logic rst, input logic [7:0] op, input logic sdone);
    @(negedge clk);
    reset                 = rst;
    bus.req_mem_operation = op;
    bus.sram_opdone       = sdone;
    #1;
  endtask

  initial begin
    logic [7:0] m;
    logic [3:0] exp_g;

    reset                 = 1'b1;
    bus.req_mem_operation = '0;
    bus.req_addr          = {A3, A2, A1, A0};
    bus.req_wdata         = {W3, W2, W1, W0};
    bus.sram_opdone       = 1'b0;
    bus.sram_rdata        = '0;
    repeat (2) @(negedge clk);

    //            rst  op     dn  grant sop    addr  wdata dn     err
    vecs.push_back('{1, 8'h01, 1, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0}); // reset state
    vecs.push_back('{0, 8'h00, 0, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0});
    vecs.push_back('{0, 8'h01, 0, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0}); // req0 reads
    vecs.push_back('{0, 8'h01, 1, 4'h1, 2'b01, A0,    W0,    4'h1, 0});
    vecs.push_back('{0, 8'h01, 0, 4'h1, 2'b01, A0,    W0,    4'h0, 0});
    vecs.push_back('{0, 8'h01, 1, 4'h1, 2'b01, A0,    W0,    4'h1, 0});
    vecs.push_back('{0, 8'h01, 1, 4'h1, 2'b01, A0,    W0,    4'h1, 0});
    vecs.push_back('{0, 8'h00, 0, 4'h1, 2'b00, A0,    W0,    4'h0, 0}); // drop
    vecs.push_back('{0, 8'h00, 1, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0}); // GAP ignores opdone
    vecs.push_back('{0, 8'h00, 0, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0});
    vecs.push_back('{0, 8'h44, 0, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0}); // req1+req3
    vecs.push_back('{0, 8'h44, 1, 4'h2, 2'b01, A1,    W1,    4'h2, 0});
    vecs.push_back('{0, 8'h40, 0, 4'h2, 2'b00, A1,    W1,    4'h0, 0}); // req1 drops
    vecs.push_back('{0, 8'h40, 0, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0}); // GAP
    vecs.push_back('{0, 8'h40, 0, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0}); // IDLE
    vecs.push_back('{0, 8'h40, 1, 4'h8, 2'b01, A3,    W3,    4'h8, 0});
    vecs.push_back('{0, 8'h00, 0, 4'h8, 2'b00, A3,    W3,    4'h0, 0});
    vecs.push_back('{0, 8'h00, 0, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0});
    vecs.push_back('{0, 8'h30, 0, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0}); // req2 writes
    vecs.push_back('{0, 8'h30, 1, 4'h4, 2'b11, A2,    W2,    4'h4, 0});
    vecs.push_back('{0, 8'h20, 0, 4'h4, 2'b00, A2,    W2,    4'h0, 0}); // code 10 releases
    vecs.push_back('{0, 8'h02, 0, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0}); // GAP
    vecs.push_back('{0, 8'h02, 0, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0}); // code 10: no request
    vecs.push_back('{0, 8'h02, 1, 4'h0, 2'b00, 12'h0, 32'h0, 4'h0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset                 = vecs[i].rst;
      bus.req_mem_operation = vecs[i].op;
      bus.sram_opdone       = vecs[i].sdone;
      bus.sram_rdata        = 32'hA5A5_0000 | 32'(i);
      #1;
      check($sformatf("v%0d.grant", i), 64'(grant), 64'(vecs[i].g));
      check($sformatf("v%0d.busy", i), 64'(busy), 64'(|vecs[i].g));
      check($sformatf("v%0d.sram_op", i), 64'(bus.sram_mem_operation), 64'(vecs[i].sop));
      check($sformatf("v%0d.sram_addr", i), 64'(bus.sram_addr), 64'(vecs[i].sa));
      check($sformatf("v%0d.sram_wdata", i), 64'(bus.sram_wdata), 64'(vecs[i].sw));
      check($sformatf("v%0d.req_opdone", i), 64'(bus.req_opdone), 64'(vecs[i].dn));
      check($sformatf("v%0d.timeout_err", i), 64'(timeout_err), 64'(vecs[i].err));
      check($sformatf("v%0d.req_rdata", i), 64'(bus.req_rdata), 64'(32'hA5A5_0000 | 32'(i)));
    end

    // Fairness: all four hold 01; each owner drops in the same cycle as its
    // single opdone, which must still be delivered.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'h55, 1'b0);
    check("rr.idle0.grant", 64'(grant), 64'(4'h0));
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'(1 << (n % 4));
      m = 8'h55;
      m[2*(n%4) +: 2] = 2'b00;
      cyc(1'b0, m, 1'b1);
      check($sformatf("rr%0d.grant", n), 64'(grant), 64'(exp_g));
      check($sformatf("rr%0d.opdone", n), 64'(bus.req_opdone), 64'(exp_g));
      check($sformatf("rr%0d.own_op", n), 64'(bus.sram_mem_operation), 64'(2'b00));
      cyc(1'b0, 8'h55, 1'b0);
      check($sformatf("rr%0d.gap_grant", n), 64'(grant), 64'(4'h0));
      check($sformatf("rr%0d.gap_op", n), 64'(bus.sram_mem_operation), 64'(2'b00));
      cyc(1'b0, 8'h55, 1'b0);
      check($sformatf("rr%0d.idle_grant", n), 64'(grant), 64'(4'h0));
    end

    // Watchdog: req0 owns and never sees opdone. The 16th OWN edge sets the
    // flag, so it reads 0 through OWN cycle 16 and 1 from cycle 17.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'h01, 1'b0);
    check("wd.idle.grant", 64'(grant), 64'(4'h0));
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b0, 8'h01, 1'b0);
      check($sformatf("wd.c%0d.grant", k), 64'(grant), 64'(4'h1));
      check($sformatf("wd.c%0d.err", k), 64'(timeout_err), 64'(1'b0));
    end
    cyc(1'b0, 8'h01, 1'b0);
    check("wd.c17.err", 64'(timeout_err), 64'(1'b1));
    // Owner releases and req2 asks: grant must stay frozen on req0.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 8'h10, 1'b0);
      check($sformatf("wd.hold%0d.grant", k), 64'(grant), 64'(4'h1));
      check($sformatf("wd.hold%0d.err", k), 64'(timeout_err), 64'(1'b1));
    end
    check("wd.hold.op", 64'(bus.sram_mem_operation), 64'(2'b00));

    // Reset during a req1 burst, then req0 and req1 compete.
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b0, 8'h04, 1'b0);
    check("rb.idle.err", 64'(timeout_err), 64'(1'b0));
    cyc(1'b0, 8'h04, 1'b1);
    check("rb.own.grant", 64'(grant), 64'(4'h2));
    check("rb.own.opdone", 64'(bus.req_opdone), 64'(4'h2));
    cyc(1'b1, 8'h04, 1'b1);
    check("rb.rst.op", 64'(bus.sram_mem_operation), 64'(2'b00));
    check("rb.rst.opdone", 64'(bus.req_opdone), 64'(4'h0));
    cyc(1'b0, 8'h05, 1'b0);
    check("rb.post.grant", 64'(grant), 64'(4'h0));
    check("rb.post.busy", 64'(busy), 64'(1'b0));
    check("rb.post.op", 64'(bus.sram_mem_operation), 64'(2'b00));
    check("rb.post.err", 64'(timeout_err), 64'(1'b0));
    cyc(1'b0, 8'h05, 1'b0);
    check("rb.first.grant", 64'(grant), 64'(4'h1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
